// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-to-hazard-controller signal bundle; master = pipeline, slave = controller.
interface hazard_ctrl_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] IFID_rs, IFID_rt, IDEX_rt;
  logic IDEX_memread, branch_taken, dmem_req, dmem_ack;
  logic PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold, mem_err;
  modport master (
    output IFID_rs, IFID_rt, IDEX_rt, IDEX_memread, branch_taken, dmem_req, dmem_ack,
    input  PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold, mem_err
  );
  modport slave (
    input  IFID_rs, IFID_rt, IDEX_rt, IDEX_memread, branch_taken, dmem_req, dmem_ack,
    output PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold, mem_err
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / D-memory-wait hazard control for the 5-stage pipeline.
//   clk_i, rst_i (async, active-low); hz: hazard_ctrl_if.slave (register indices, load flag,
//   branch_taken, dmem req/ack in; PC/IFID write, IFID flush, IDEX bubble, pipe_hold, mem_err out).
//   HAZARD_PERF_EN adds stall_cnt / flush_cnt outputs of width CNT_W.
module hazard_ctrl #(
  parameter int MISS_TMO = 16
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  typedef enum logic {RUN, MEMWAIT} state_t;
  localparam logic [7:0] TMO = 8'(MISS_TMO);
  state_t state;
  logic [7:0] tmo_cnt;
  logic err, lu, mstall, go;
  assign lu = hz.IDEX_memread && hz.IDEX_rt != '0 &&
              (hz.IDEX_rt == hz.IFID_rs || hz.IDEX_rt == hz.IFID_rt);
  // In MEMWAIT the request is assumed held, so only the ack matters.
  assign mstall = state == RUN ? hz.dmem_req && !hz.dmem_ack : !hz.dmem_ack;
  assign go = rst_i && !mstall && !lu;
  assign hz.PC_write    = go;
  assign hz.IFID_write  = go;
  assign hz.IFID_flush  = go && hz.branch_taken;
  assign hz.IDEX_bubble = !rst_i || (!mstall && lu);
  assign hz.pipe_hold   = rst_i && mstall;
  assign hz.mem_err     = rst_i && err;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      tmo_cnt <= '0;
      err <= 1'b0;
    end else if (state == RUN) begin
      if (hz.dmem_req && !hz.dmem_ack) begin
        state <= MEMWAIT;
        tmo_cnt <= 8'd1;
      end
    end else if (hz.dmem_ack) begin
      state <= RUN;
      tmo_cnt <= '0;
    end else if (tmo_cnt == TMO) begin
      err <= 1'b1;
    end else begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(!hz.PC_write);
      flush_cnt <= flush_cnt + CNT_W'(hz.IFID_flush);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl (MISS_TMO=4).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int checks = 0;
  int errors = 0;
  // {PC_write, IFID_write, IFID_flush, IDEX_bubble, pipe_hold, mem_err}
  localparam logic [5:0] RST  = 6'b000100;
  localparam logic [5:0] NORM = 6'b110000;
  localparam logic [5:0] LU   = 6'b000100;
  localparam logic [5:0] BR   = 6'b111000;
  localparam logic [5:0] HOLD = 6'b000010;
  localparam logic [5:0] ERR  = 6'b000001;
  hazard_ctrl_if #(.REG_W(5)) hz ();
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
  hazard_ctrl #(.MISS_TMO(4)) dut (.clk_i(clk), .rst_i(rst_i), .hz(hz),
                                   .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  hazard_ctrl #(.MISS_TMO(4)) dut (.clk_i(clk), .rst_i(rst_i), .hz(hz));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask
  task automatic outs(input string tag, input logic [5:0] exp);
    chk(tag, 16'({hz.PC_write, hz.IFID_write, hz.IFID_flush, hz.IDEX_bubble, hz.pipe_hold, hz.mem_err}),
        16'(exp));
  endtask
  task automatic step(input string tag, input logic [4:0] rs, rt, idrt,
                      input logic mr, bt, req, ack, input logic [5:0] exp);
    hz.IFID_rs = rs;
    hz.IFID_rt = rt;
    hz.IDEX_rt = idrt;
    hz.IDEX_memread = mr;
    hz.branch_taken = bt;
    hz.dmem_req = req;
    hz.dmem_ack = ack;
    #1;
    outs(tag, exp);
    @(negedge clk);
  endtask
  initial begin
    step("rst0", 5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, RST);
    step("rst1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, RST);
    rst_i = 1'b1;
    step("idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    step("lu", 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    step("lu_rel", 5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    step("lu_r0", 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM);
    step("br", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, BR);
    step("br_lu", 5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, LU);
    step("mw0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD);
    step("mw1_br", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, HOLD);
    step("mw2_br_lu", 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, HOLD);
    step("mw3_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR);
    step("run_back", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", stall_cnt, 16'd5);
    chk("flush_cnt", flush_cnt, 16'd2);
`endif
    step("zw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, NORM);
    step("zw_run", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    step("tmo0", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD);
    step("tmo1", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD);
    step("tmo2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD);
    step("tmo3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD);
    step("tmo4", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HOLD);
    step("tmo5_err", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HOLD | ERR);
    step("err_ack", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NORM | ERR);
    step("err_stick", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM | ERR);
    step("pre_rst_mw", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, HOLD | ERR);
    step("pre_rst_mw2", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, HOLD | ERR);
    rst_i = 1'b0;
    #1;
    outs("rst_async", RST);
    #2;
    rst_i = 1'b1;
    @(negedge clk);
    step("post_rst", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
    step("post_rst_lu", 5'd3, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
